// File: rtl/jt12_opacc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jt12_opacc_pkg
// Purpose : Shared constants and types for the operator output accumulator.
// Rev     : 1.0  initial release
// ============================================================================
package jt12_opacc_pkg;

  // Operators arrive in the order S1,S3,S2,S4; each group spans six channels
  typedef enum logic [1:0] {
    GRP_S1 = 2'd0,
    GRP_S3 = 2'd1,
    GRP_S2 = 2'd2,
    GRP_S4 = 2'd3
  } grp_e;

  localparam int         c_SLOTS     = 24;
  localparam int         c_NUM_CH    = 6;
  localparam int         c_ACC_W     = 11;
  localparam int         c_MIX_W     = 14;
  localparam logic [4:0] c_LAST_SLOT = 5'(c_SLOTS - 1);

  // Indexed [alg][grp]; a set bit marks that operator group as a carrier
  localparam logic [7:0][3:0] c_CARRIER_MASK = {
    4'b1111,  // alg 7
    4'b1110,  // alg 6
    4'b1110,  // alg 5
    4'b1100,  // alg 4
    4'b1000,  // alg 3
    4'b1000,  // alg 2
    4'b1000,  // alg 1
    4'b1000   // alg 0
  };

endpackage
`default_nettype wire

// File: rtl/jt12_opacc_ring.sv
`default_nettype none
// ============================================================================
// Module  : jt12_opacc_ring
// Purpose : N-stage x W-bit shift register with synchronous active-low reset.
// Rev     : 1.0  initial release
// ============================================================================
module jt12_opacc_ring #(
  parameter int N = 6,
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] r_stage [N];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < N; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= din;
      for (int i = 1; i < N; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign dout = r_stage[N-1];

endmodule
`default_nettype wire

// File: rtl/jt12_opacc.sv
`default_nettype none
// ============================================================================
// Module  : jt12_opacc
// Purpose : Sums carrier operators per channel, pans and mixes six channels
//           into one saturated stereo sample per 24-slot frame.
// Rev     : 1.0  initial release
// ============================================================================
module jt12_opacc
  import jt12_opacc_pkg::*;
#(
  parameter int OUT_W   = 12,
  parameter int PCM_SHL = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    zero,
  input  logic signed [8:0]       op_result,
  input  logic [2:0]              alg,
  input  logic [1:0]              rl,
  input  logic                    pcm_en,
  input  logic signed [8:0]       pcm,
  output logic signed [OUT_W-1:0] left,
  output logic signed [OUT_W-1:0] right,
  output logic                    sample
);

  logic [4:0]                 r_cnt;
  logic [4:0]                 w_cnt;
  grp_e                       w_grp;
  logic                       w_last;
  logic                       r_synced;
  logic                       r_frame_ok;
  logic signed [c_ACC_W-1:0]  w_contrib;
  logic signed [c_ACC_W-1:0]  w_ring_in;
  logic signed [c_ACC_W-1:0]  w_ring_out;
  logic signed [c_ACC_W-1:0]  w_pcm_ext;
  logic signed [c_ACC_W-1:0]  w_chsum;
  logic signed [c_MIX_W-1:0]  w_chsum_x;
  logic signed [c_MIX_W-1:0]  r_mix_l;
  logic signed [c_MIX_W-1:0]  r_mix_r;
  logic signed [c_MIX_W-1:0]  w_mix_l_nxt;
  logic signed [c_MIX_W-1:0]  w_mix_r_nxt;
  logic signed [OUT_W-1:0]    w_sat_l;
  logic signed [OUT_W-1:0]    w_sat_r;

  // zero overrides the free-running count in the very cycle it is seen
  assign w_cnt  = zero ? 5'd0 : r_cnt;
  assign w_last = (w_cnt == c_LAST_SLOT);

  always_comb begin
    w_grp = GRP_S4;
    if      (w_cnt < 5'd6)  w_grp = GRP_S1;
    else if (w_cnt < 5'd12) w_grp = GRP_S3;
    else if (w_cnt < 5'd18) w_grp = GRP_S2;
  end

  assign w_contrib  = c_CARRIER_MASK[alg][w_grp] ? c_ACC_W'(op_result) : '0;
  assign w_ring_in  = (w_grp == GRP_S1) ? w_contrib : w_ring_out + w_contrib;
  assign w_pcm_ext  = c_ACC_W'(pcm) <<< PCM_SHL;
  assign w_chsum    = (w_last && pcm_en) ? w_pcm_ext : w_ring_out + w_contrib;
  assign w_chsum_x  = c_MIX_W'(w_chsum);

  assign w_mix_l_nxt = r_mix_l + (rl[1] ? w_chsum_x : 14'sd0);
  assign w_mix_r_nxt = r_mix_r + (rl[0] ? w_chsum_x : 14'sd0);

  jt12_opacc_ring #(
    .N (c_NUM_CH),
    .W (c_ACC_W)
  ) u_ring (
    .clk  (clk),
    .rst  (rst),
    .din  (w_ring_in),
    .dout (w_ring_out)
  );

  generate
    if (OUT_W >= c_MIX_W) begin : g_sat_pass
      assign w_sat_l = OUT_W'(w_mix_l_nxt);
      assign w_sat_r = OUT_W'(w_mix_r_nxt);
    end else begin : g_sat_clip
      localparam logic signed [c_MIX_W-1:0] c_MAX = c_MIX_W'((1 <<< (OUT_W-1)) - 1);
      localparam logic signed [c_MIX_W-1:0] c_MIN = c_MIX_W'(-(1 <<< (OUT_W-1)));
      assign w_sat_l = (w_mix_l_nxt > c_MAX) ? OUT_W'(c_MAX) :
                       (w_mix_l_nxt < c_MIN) ? OUT_W'(c_MIN) : OUT_W'(w_mix_l_nxt);
      assign w_sat_r = (w_mix_r_nxt > c_MAX) ? OUT_W'(c_MAX) :
                       (w_mix_r_nxt < c_MIN) ? OUT_W'(c_MIN) : OUT_W'(w_mix_r_nxt);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_synced   <= 1'b0;
      r_frame_ok <= 1'b0;
      r_mix_l    <= '0;
      r_mix_r    <= '0;
      left       <= '0;
      right      <= '0;
      sample     <= 1'b0;
    end else begin
      r_cnt    <= w_last ? 5'd0 : w_cnt + 5'd1;
      r_synced <= r_synced | zero;
      sample   <= 1'b0;
      // A frame only counts if its slot 0 was seen after the first zero
      if (w_cnt == 5'd0) r_frame_ok <= r_synced | zero;
      if (w_last || w_cnt == 5'd0) begin
        r_mix_l <= '0;
        r_mix_r <= '0;
      end else if (w_grp == GRP_S4) begin
        r_mix_l <= w_mix_l_nxt;
        r_mix_r <= w_mix_r_nxt;
      end
      if (w_last && r_frame_ok) begin
        left   <= w_sat_l;
        right  <= w_sat_r;
        sample <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jt12_opacc.sv
`default_nettype none
// ============================================================================
// Module  : tb_jt12_opacc
// Purpose : Directed frames with a strobe-driven scoreboard for jt12_opacc.
// Rev     : 1.0  initial release
// ============================================================================
module tb_jt12_opacc;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              zero = 1'b0;
  logic signed [8:0] op_result = '0;
  logic [2:0]        alg = '0;
  logic [1:0]        rl = '0;
  logic              pcm_en = 1'b0;
  logic signed [8:0] pcm = '0;
  logic signed [11:0] left;
  logic signed [11:0] right;
  logic              sample;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int l;
    int r;
    int c;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  jt12_opacc #(
    .OUT_W   (12),
    .PCM_SHL (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .zero      (zero),
    .op_result (op_result),
    .alg       (alg),
    .rl        (rl),
    .pcm_en    (pcm_en),
    .pcm       (pcm),
    .left      (left),
    .right     (right),
    .sample    (sample)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  exp_t e;
  always @(negedge clk) begin
    if (sample === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_strobe", 1, 0);
      end else begin
        e = q.pop_front();
        chk("left", int'(left), e.l);
        chk("right", int'(right), e.r);
        chk("strobe_cycle", cyc, e.c);
      end
    end
  end

  task automatic drive(input logic z, input int op, input logic [2:0] a,
                       input logic [1:0] p, input logic pe, input int pv);
    zero      = z;
    op_result = 9'(op);
    alg       = a;
    rl        = p;
    pcm_en    = pe;
    pcm       = 9'(pv);
    @(posedge clk);
    #1;
  endtask

  // Drives nslots slots starting with zero; ops given per group S1,S3,S2,S4
  task automatic frame(input int nslots, input logic [2:0] a, input logic [1:0] p,
                       input int o1, input int o3, input int o2, input int o4,
                       input logic pe, input int pv,
                       input bit push, input int el, input int er);
    for (int c = 0; c < nslots; c++) begin
      int o;
      o = (c < 6) ? o1 : (c < 12) ? o3 : (c < 18) ? o2 : o4;
      if (push && c == 23) q.push_back('{el, er, cyc + 1});
      drive(c == 0, o, a, p, pe, pv);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_left", int'(left), 0);
    chk("reset_right", int'(right), 0);
    chk("reset_sample", int'(sample), 0);
    rst = 1'b1;

    frame(24, 3'd7, 2'b11, 10, 10, 10, 10, 1'b0, 0, 1'b1, 240, 240);
    frame(24, 3'd0, 2'b10, 100, 100, 100, 5, 1'b0, 0, 1'b1, 30, 0);
    frame(24, 3'd4, 2'b01, 100, 100, 20, 3, 1'b0, 0, 1'b1, 0, 138);
    frame(24, 3'd5, 2'b11, 100, -7, 20, 3, 1'b0, 0, 1'b1, 96, 96);
    frame(24, 3'd7, 2'b11, 255, 255, 255, 255, 1'b0, 0, 1'b1, 2047, 2047);
    frame(24, 3'd7, 2'b11, -256, -256, -256, -256, 1'b0, 0, 1'b1, -2048, -2048);
    frame(24, 3'd0, 2'b11, 0, 0, 0, 0, 1'b1, -64, 1'b1, -256, -256);
    frame(24, 3'd0, 2'b11, 0, 0, 0, 0, 1'b0, -64, 1'b1, 0, 0);
    frame(24, 3'd7, 2'b11, 10, 10, 10, 10, 1'b1, 100, 1'b1, 600, 600);

    // Mid-frame resync at cnt=10 and at cnt=20 (inside the mixing group)
    frame(10, 3'd7, 2'b11, 10, 10, 10, 10, 1'b0, 0, 1'b0, 0, 0);
    frame(24, 3'd0, 2'b11, 0, 0, 0, 50, 1'b0, 0, 1'b1, 300, 300);
    frame(20, 3'd7, 2'b11, 10, 10, 10, 10, 1'b0, 0, 1'b0, 0, 0);
    chk("hold_left", int'(left), 300);
    chk("hold_right", int'(right), 300);
    frame(24, 3'd0, 2'b01, 0, 0, 0, -20, 1'b0, 0, 1'b1, 0, -120);

    // Reset pulse at cnt=15, then free-running slots with no zero
    frame(15, 3'd7, 2'b11, 10, 10, 10, 10, 1'b0, 0, 1'b0, 0, 0);
    rst = 1'b0;
    drive(1'b0, 10, 3'd7, 2'b11, 1'b0, 0);
    chk("rst_left", int'(left), 0);
    chk("rst_right", int'(right), 0);
    chk("rst_sample", int'(sample), 0);
    rst = 1'b1;
    for (int i = 0; i < 30; i++) drive(1'b0, 10, 3'd7, 2'b11, 1'b0, 0);
    frame(24, 3'd7, 2'b11, 10, 10, 10, 10, 1'b0, 0, 1'b1, 240, 240);

    for (int i = 0; i < 4; i++) drive(1'b0, 0, 3'd0, 2'b00, 1'b0, 0);
    chk("pending_strobes", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
